ecc_err_log: RTL
================

// Module: ecc_err_log
//
// PURPOSE
//   Error logger that sits directly downstream of ecc_dec. It consumes the
//   per-word decode status and the access address, and keeps saturating
//   corrected-error (CE) and uncorrectable-error (UE) counters. It captures
//   the first error record and raises sticky interrupts for software or
//   scrub control. All outputs are registered.
//
// PARAMETERS
//   ADDR_WIDTH  32  width of the access address logged with each error
//   CNT_WIDTH   16  width of the CE and UE counters and of ce_thresh
//   TS_WIDTH    32  width of the free-running timestamp (ECC_ERR_LOG_TS_EN only)
//
// PORTS
//   clk        in   1           clock
//   rstn       in   1           asynchronous active-low reset
//   in_valid   in   1           err_sts_in/addr_in are valid this cycle
//   err_sts_in in   2           decoder status: 00 ok, 01 CE (single-bit corrected),
//                               10 UE (double-bit detected), 11 treated as UE
//   addr_in    in   ADDR_WIDTH  address of the decoded word
//   clr        in   1           1-cycle pulse: clear counters, capture, irqs
//   ce_thresh  in   CNT_WIDTH   CE interrupt threshold; 0 disables irq_ce
//   ce_cnt     out  CNT_WIDTH   saturating CE count
//   ue_cnt     out  CNT_WIDTH   saturating UE count
//   cap_valid  out  1           capture registers hold an error record
//   cap_sts    out  2           captured status (01 or 10; input 11 is logged as 10)
//   cap_addr   out  ADDR_WIDTH  captured address
//   cap_ovf    out  1           an error arrived while the capture was locked
//   irq_ce     out  1           sticky; set when ce_cnt >= ce_thresh != 0
//   irq_ue     out  1           sticky; set on any UE
//   cap_ts     out  TS_WIDTH    timestamp of capture (ECC_ERR_LOG_TS_EN only)
//
// BEHAVIOUR
//   - Reset: every output and all internal state are 0. FSM is in IDLE.
//   - An event is a cycle with in_valid=1 and err_sts_in!=00. Its effect is
//     visible on the outputs on the following clock edge (latency 1).
//   - in_valid=0 or err_sts_in=00: no state change.
//   - Counters: CE increments ce_cnt; UE (10 or 11) increments ue_cnt. Each
//     counter saturates at all-ones and never wraps.
//   - Capture FSM:
//       IDLE   -CE-> CAP_CE  (load sts=01, addr; cap_valid=1)
//       IDLE   -UE-> CAP_UE  (load sts=10, addr; cap_valid=1)
//       CAP_CE -UE-> CAP_UE  (UE upgrades the record: reload sts/addr, set cap_ovf)
//       CAP_CE -CE-> CAP_CE  (record kept, set cap_ovf)
//       CAP_UE -any-> CAP_UE (record kept, set cap_ovf)
//       any    -clr-> IDLE
//   - irq_ce: set on the edge where the updated ce_cnt >= ce_thresh and
//     ce_thresh != 0. It is also set if ce_thresh is lowered to <= the current
//     ce_cnt. It stays set until clr.
//   - irq_ue: set with the first UE and stays set until clr.
//   - clr priority: clr wins over a same-cycle event. The event is dropped, and
//     all counters, capture registers, cap_ovf and irqs go to 0 on the next edge.
//   - Reset mid-operation: asynchronous return to the reset values above.
//     Clocking resumes from IDLE.
//
// CONFIGURATION
//   ECC_ERR_LOG_TS_EN defined:
//     - A free-running TS_WIDTH counter runs from 0 after reset and wraps.
//     - Its value is loaded into cap_ts on every capture load (IDLE->CAP_*,
//       CAP_CE->CAP_UE). clr zeroes cap_ts but not the running counter.
//   ECC_ERR_LOG_TS_EN undefined:
//     - No timestamp logic and no cap_ts port.
//
// TESTING
//   1 reset, 5 valid words sts=00 -> all outputs 0, FSM IDLE
//   2 ce_thresh=3, three CE at addr 0x10,0x20,0x30 -> ce_cnt=3, cap_addr=0x10,
//     cap_sts=01, cap_ovf=1, irq_ce=1 on the edge after the third CE
//   3 CE @0x40 then UE (sts=11) @0x80 -> cap_sts=10, cap_addr=0x80, cap_ovf=1,
//     ue_cnt=1, irq_ue=1
//   4 CNT_WIDTH=4, 20 UE -> ue_cnt holds at 0xF, no wrap
//   5 clr together with a CE -> next cycle ce_cnt=0, cap_valid=0, irq_ce=0
//     (event dropped); the next CE then captures normally
//   6 ECC_ERR_LOG_TS_EN: first CE 100 cycles after reset release -> cap_ts=100
//     (+/-1 per the documented sample edge); rstn low mid-stream -> all 0

Source files
------------

// File: rtl/ecc_err_log_if.sv
// Interface between the ECC decoder side (master) and the error logger (slave).
// cap_ts exists only when ECC_ERR_LOG_TS_EN is defined.
interface ecc_err_log_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
`ifdef ECC_ERR_LOG_TS_EN
  ,
  parameter int TS_WIDTH   = 32
`endif
);
  logic                  in_valid;
  logic [1:0]            err_sts_in;
  logic [ADDR_WIDTH-1:0] addr_in;
  logic                  clr;
  logic [CNT_WIDTH-1:0]  ce_thresh;
  logic [CNT_WIDTH-1:0]  ce_cnt;
  logic [CNT_WIDTH-1:0]  ue_cnt;
  logic                  cap_valid;
  logic [1:0]            cap_sts;
  logic [ADDR_WIDTH-1:0] cap_addr;
  logic                  cap_ovf;
  logic                  irq_ce;
  logic                  irq_ue;
`ifdef ECC_ERR_LOG_TS_EN
  logic [TS_WIDTH-1:0]   cap_ts;
`endif

  modport master (
    output in_valid, err_sts_in, addr_in, clr, ce_thresh,
`ifdef ECC_ERR_LOG_TS_EN
    input  cap_ts,
`endif
    input  ce_cnt, ue_cnt, cap_valid, cap_sts, cap_addr, cap_ovf, irq_ce, irq_ue
  );

  modport slave (
    input  in_valid, err_sts_in, addr_in, clr, ce_thresh,
`ifdef ECC_ERR_LOG_TS_EN
    output cap_ts,
`endif
    output ce_cnt, ue_cnt, cap_valid, cap_sts, cap_addr, cap_ovf, irq_ce, irq_ue
  );
endinterface

// File: rtl/ecc_err_log.sv
// ECC error logger: saturating CE/UE counters, first-error capture, sticky irqs.
// Optional capture timestamp enabled by defining ECC_ERR_LOG_TS_EN.
module ecc_err_log #(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
`ifdef ECC_ERR_LOG_TS_EN
  ,
  parameter int TS_WIDTH   = 32
`endif
) (
  input logic           clk,
  input logic           rstn,
  ecc_err_log_if.slave  bus
);

  // State encoding doubles as the captured status code.
  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] CAP_CE = 2'b01;
  localparam logic [1:0] CAP_UE = 2'b10;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic                 [1:0] state;
  logic                 [1:0] state_nxt;
  logic                       is_ev;
  logic                       is_ce;
  logic                       is_ue;
  logic                       cap_load;
  logic       [CNT_WIDTH-1:0] ce_cnt_nxt;

  assign is_ev = bus.in_valid && (bus.err_sts_in != 2'b00);
  assign is_ue = is_ev && bus.err_sts_in[1];
  assign is_ce = is_ev && !bus.err_sts_in[1];

  assign ce_cnt_nxt = (is_ce && bus.ce_cnt != CNT_MAX) ? bus.ce_cnt + CNT_WIDTH'(1) : bus.ce_cnt;

  always_comb begin
    // NOTE: defaults first so every path assigns every output -- no latches.
    state_nxt = state;
    cap_load  = 1'b0;
    case (state)
      IDLE: begin
        if (is_ev) begin
          state_nxt = is_ue ? CAP_UE : CAP_CE;
          cap_load  = 1'b1;
        end
      end
      CAP_CE: begin
        if (is_ue) begin
          state_nxt = CAP_UE;
          cap_load  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!rstn) begin
      state         <= IDLE;
      bus.ce_cnt    <= '0;
      bus.ue_cnt    <= '0;
      bus.cap_valid <= 1'b0;
      bus.cap_sts   <= 2'b00;
      bus.cap_addr  <= '0;
      bus.cap_ovf   <= 1'b0;
      bus.irq_ce    <= 1'b0;
      bus.irq_ue    <= 1'b0;
    end else if (bus.clr) begin
      // clr beats any same-cycle event; that event is discarded.
      state         <= IDLE;
      bus.ce_cnt    <= '0;
      bus.ue_cnt    <= '0;
      bus.cap_valid <= 1'b0;
      bus.cap_sts   <= 2'b00;
      bus.cap_addr  <= '0;
      bus.cap_ovf   <= 1'b0;
      bus.irq_ce    <= 1'b0;
      bus.irq_ue    <= 1'b0;
    end else begin
      state         <= state_nxt;
      bus.ce_cnt    <= ce_cnt_nxt;
      bus.cap_valid <= (state_nxt != IDLE);
      bus.cap_sts   <= state_nxt;
      if (is_ue && bus.ue_cnt != CNT_MAX) bus.ue_cnt <= bus.ue_cnt + CNT_WIDTH'(1);
      if (cap_load) bus.cap_addr <= bus.addr_in;
      if (is_ev && state != IDLE) bus.cap_ovf <= 1'b1;
      if (is_ue) bus.irq_ue <= 1'b1;
      // Evaluated every cycle so lowering ce_thresh alone can raise the irq.
      if (bus.ce_thresh != '0 && ce_cnt_nxt >= bus.ce_thresh) bus.irq_ce <= 1'b1;
    end
  end

`ifdef ECC_ERR_LOG_TS_EN
  logic [TS_WIDTH-1:0] ts;

  // Free-running counter is not affected by clr, only by reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ts         <= '0;
      bus.cap_ts <= '0;
    end else begin
      ts <= ts + TS_WIDTH'(1);
      if (bus.clr) bus.cap_ts <= '0;
      else if (cap_load) bus.cap_ts <= ts;
    end
  end
`endif

endmodule
